// File: rtl/i2c_master_1.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL by holding scl_in low in q1/q2.
module i2c_master_1 #(
  parameter int DIVIDE_BY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] data_wr,
  output logic [7:0] data_rd,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_in,
  input  logic       scl_in
);
  localparam int QW = $clog2(DIVIDE_BY);
  localparam logic [QW-1:0] QMAX = QW'(DIVIDE_BY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_STOP
  } state_t;

  state_t          state, state_nxt;
  logic [QW-1:0]   qcnt;
  logic [1:0]      q;
  logic [2:0]      bitn;
  logic [6:0]      addr_q;
  logic            rw_q;
  logic [7:0]      dwr_q, shreg, tx_byte;
  logic            accept, stall, tick, slot_end, samp;

  assign tx_byte  = {addr_q, rw_q};
  assign busy     = (state != S_IDLE);
  // A request landing on the done cycle is dropped, not queued.
  assign accept   = (state == S_IDLE) && start && !done;
  assign tick     = (qcnt == QMAX) && !stall;
  assign slot_end = tick && (q == 2'd3);
  assign samp     = tick && (q == 2'd2);

`ifdef I2C_CLK_STRETCH_EN
  assign stall = scl && ((q == 2'd1) || (q == 2'd2)) && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall = 1'b0;
`endif

  // Line levels depend only on state and quarter.
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state)
      S_IDLE:    ;
      S_START:   begin scl = (q != 2'd3); sda_oe = q[1]; end
      S_ADDR:    begin scl = (q != 2'd0); sda_oe = ~tx_byte[3'd7 - bitn]; end
      S_WR_DATA: begin scl = (q != 2'd0); sda_oe = ~dwr_q[3'd7 - bitn]; end
      S_STOP:    begin scl = (q != 2'd0); sda_oe = ~q[1]; end
      default:   scl = (q != 2'd0);
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept) state_nxt = S_START;
      S_START:    if (slot_end) state_nxt = S_ADDR;
      S_ADDR:     if (slot_end && bitn == 3'd7) state_nxt = S_ADDR_ACK;
      S_ADDR_ACK: if (slot_end) state_nxt = ack_err ? S_STOP : (rw_q ? S_RD_DATA : S_WR_DATA);
      S_WR_DATA:  if (slot_end && bitn == 3'd7) state_nxt = S_WR_ACK;
      S_RD_DATA:  if (slot_end && bitn == 3'd7) state_nxt = S_RD_ACK;
      S_WR_ACK,
      S_RD_ACK:   if (slot_end) state_nxt = S_STOP;
      S_STOP:     if (slot_end) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qcnt    <= '0;
      q       <= 2'd0;
      bitn    <= 3'd0;
      addr_q  <= 7'd0;
      rw_q    <= 1'b0;
      dwr_q   <= 8'd0;
      shreg   <= 8'd0;
      data_rd <= 8'd0;
      ack_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == S_STOP) && slot_end;
      if (accept) begin
        qcnt    <= '0;
        q       <= 2'd0;
        bitn    <= 3'd0;
        addr_q  <= addr;
        rw_q    <= rw;
        dwr_q   <= data_wr;
        ack_err <= 1'b0;
      end else begin
        if (!stall) qcnt <= (qcnt == QMAX) ? '0 : qcnt + QW'(1);
        if (tick) q <= q + 2'd1;
        if (slot_end)
          bitn <= (state inside {S_ADDR, S_WR_DATA, S_RD_DATA}) ? bitn + 3'd1 : 3'd0;
        if (samp && (state inside {S_ADDR_ACK, S_WR_ACK}) && sda_in) ack_err <= 1'b1;
        if (samp && state == S_RD_DATA) shreg <= {shreg[6:0], sda_in};
        if (slot_end && state == S_RD_ACK) data_rd <= shreg;
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_1.sv
// Bench for i2c_master_1: slot-table bus model, bus monitor and a responding slave.
`timescale 1ns/1ps
module tb_i2c_master_1;
  localparam int D = 4;
`ifdef I2C_CLK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif
  localparam int K_ST = 0, K_DRV = 1, K_REL = 2, K_SP = 3;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, rw = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] data_wr = 8'd0;
  logic [7:0] data_rd;
  logic busy, done, ack_err, scl, sda_oe, sda_in, scl_in;
  logic slave_pull = 1'b0, scl_hold = 1'b1;

  assign sda_in = ~(sda_oe | slave_pull);
  assign scl_in = scl & scl_hold;

  i2c_master_1 #(.DIVIDE_BY(D)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .data_wr(data_wr),
    .data_rd(data_rd), .busy(busy), .done(done), .ack_err(ack_err),
    .scl(scl), .sda_oe(sda_oe), .sda_in(sda_in), .scl_in(scl_in)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // transaction configuration, shared by stimulus, slave and model
  bit cfg_rw, cfg_pres, cfg_dack, cfg_str;
  logic [6:0] cfg_addr;
  logic [7:0] cfg_data, cfg_rb;

  int sk[32];
  bit sb[32], sp[32];
  int nsl, k, T, sc_left;
  bit mact = 1'b0, dcyc = 1'b0, acc_evt = 1'b0, stall_prev, stretched;
  logic [7:0] exp_drd = 8'd0;
  bit exp_err = 1'b0;
  int mon_start = 0, mon_stop = 0, mcnt = 0, st0, sp0;
  bit mbits[64];
  bit pscl = 1'b1, psda = 1'b1;
  logic [7:0] mon_abyte, mon_dbyte;
  bit mon_ackbit, mon_last;

  task automatic add(input int kind, input bit b, input bit p);
    sk[nsl] = kind; sb[nsl] = b; sp[nsl] = p; nsl++;
  endtask

  // Expected bus as a list of slots; each slot is 4 quarters of D clocks.
  task automatic build();
    logic [7:0] ab;
    ab = {cfg_addr, cfg_rw};
    nsl = 0;
    add(K_ST, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) add(K_DRV, ab[i], 1'b0);
    add(K_REL, 1'b0, cfg_pres);
    if (cfg_pres) begin
      if (!cfg_rw) begin
        for (int i = 7; i >= 0; i--) add(K_DRV, cfg_data[i], 1'b0);
        add(K_REL, 1'b0, cfg_dack);
      end else begin
        for (int i = 7; i >= 0; i--) add(K_REL, 1'b0, ~cfg_rb[i]);
        add(K_REL, 1'b0, 1'b0);
      end
    end
    add(K_SP, 1'b0, 1'b0);
    T = nsl * 4 * D;
  endtask

  always @(posedge clk or negedge reset)
    if (!reset) acc_evt <= 1'b0;
    else        acc_evt <= start && !mact && !dcyc;

  // Model, slave and monitor: everything is looked at mid-cycle.
  initial begin : model
    int s, qq;
    bit es, eo;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      // bus monitor (master SCL, wired SDA)
      if (pscl && scl && psda && !sda_in) begin mon_start++; mcnt = 0; end
      else if (pscl && scl && !psda && sda_in) mon_stop++;
      else if (!pscl && scl && mcnt < 64) begin mbits[mcnt] = sda_in; mcnt++; end
      pscl = scl; psda = sda_in;
      dcyc = 1'b0;
      if (!reset) begin
        mact = 1'b0; slave_pull = 1'b0; scl_hold = 1'b1; sc_left = 0; stall_prev = 1'b0;
        exp_drd = 8'd0; exp_err = 1'b0;
        chk("rst_scl", 32'(scl), 1);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ack_err", 32'(ack_err), 0);
        chk("rst_data_rd", 32'(data_rd), 0);
      end else begin
        if (acc_evt) begin
          build(); mact = 1'b1; k = 0; stretched = 1'b0; st0 = mon_start; sp0 = mon_stop;
        end else if (mact && !stall_prev) k++;
        if (mact && k < T) begin
          s = (k / D) / 4; qq = (k / D) % 4;
          case (sk[s])
            K_ST:    begin es = (qq != 3); eo = (qq >= 2); end
            K_DRV:   begin es = (qq != 0); eo = !sb[s]; end
            K_REL:   begin es = (qq != 0); eo = 1'b0; end
            default: begin es = (qq != 0); eo = (qq < 2); end
          endcase
          chk("busy", 32'(busy), 1);
          chk("done", 32'(done), 0);
          chk("scl", 32'(scl), 32'(es));
          chk("sda_oe", 32'(sda_oe), 32'(eo));
          slave_pull = sp[s];
          if (cfg_str && !stretched && s == 9 && qq == 1) begin sc_left = 10; stretched = 1'b1; end
          if (sc_left > 0) begin scl_hold = 1'b0; sc_left--; end
          else scl_hold = 1'b1;
          stall_prev = STRETCH && !scl_hold && es && (qq == 1 || qq == 2);
        end else if (mact) begin
          exp_err = !cfg_pres || (!cfg_rw && !cfg_dack);
          if (cfg_rw && cfg_pres) exp_drd = cfg_rb;
          chk("done_pulse", 32'(done), 1);
          chk("done_busy", 32'(busy), 0);
          chk("done_scl", 32'(scl), 1);
          chk("done_sda_oe", 32'(sda_oe), 0);
          chk("done_ack_err", 32'(ack_err), 32'(exp_err));
          chk("done_data_rd", 32'(data_rd), 32'(exp_drd));
          chk("bus_starts", mon_start - st0, 1);
          chk("bus_stops", mon_stop - sp0, 1);
          b = 8'd0;
          for (int i = 0; i < 8; i++) b = {b[6:0], mbits[i]};
          mon_abyte = b;
          mon_ackbit = mbits[8];
          chk("bus_addr_byte", 32'(mon_abyte), 32'({cfg_addr, cfg_rw}));
          chk("bus_addr_ack", 32'(mon_ackbit), 32'(!cfg_pres));
          b = 8'd0;
          for (int i = 9; i < 17; i++) b = {b[6:0], mbits[i]};
          mon_dbyte = b;
          mon_last = mbits[17];
          if (cfg_pres) chk("bus_data_byte", 32'(mon_dbyte), 32'(cfg_rw ? cfg_rb : cfg_data));
          mact = 1'b0; dcyc = 1'b1; slave_pull = 1'b0; stall_prev = 1'b0; scl_hold = 1'b1;
        end else begin
          chk("idle_busy", 32'(busy), 0);
          chk("idle_done", 32'(done), 0);
          chk("idle_scl", 32'(scl), 1);
          chk("idle_sda_oe", 32'(sda_oe), 0);
          chk("idle_ack_err", 32'(ack_err), 32'(exp_err));
          chk("idle_data_rd", 32'(data_rd), 32'(exp_drd));
        end
      end
    end
  end

  task automatic txn(input string nm, input bit r, input logic [6:0] a, input logic [7:0] d,
                     input bit pres, input bit dack, input logic [7:0] rb, input bit str,
                     input int exp_len, input int busy_pulse, input bit done_pulse,
                     input int abort_at);
    int n;
    bit got;
    cfg_rw = r; cfg_addr = a; cfg_data = d; cfg_pres = pres; cfg_dack = dack;
    cfg_rb = rb; cfg_str = str;
    rw = r; addr = a; data_wr = d;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 2000) begin
      @(posedge clk); n++;
      if (abort_at > 0 && n == abort_at) begin
        #2 reset = 1'b0;
        #1;
        chk({nm, "_async_scl"}, 32'(scl), 1);
        chk({nm, "_async_sda_oe"}, 32'(sda_oe), 0);
        chk({nm, "_async_busy"}, 32'(busy), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        return;
      end
      #1;
      start = (n == busy_pulse);
      if (done) got = 1'b1;
    end
    if (!got) chk({nm, "_timeout"}, 32'(n), 32'(exp_len));
    else      chk({nm, "_len"}, 32'(n), 32'(exp_len));
    if (done_pulse) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    txn("t1_write", 1'b0, 7'h2A, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 320, 0, 1'b0, 0);
    chk("t1_addr_byte", 32'(mon_abyte), 32'h54);
    chk("t1_data_byte", 32'(mon_dbyte), 32'hA5);
    chk("t1_ack_err", 32'(ack_err), 0);

    txn("t2_read", 1'b1, 7'h2A, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 320, 0, 1'b0, 0);
    chk("t2_addr_byte", 32'(mon_abyte), 32'h55);
    chk("t2_master_nack", 32'(mon_last), 1);
    chk("t2_data_rd", 32'(data_rd), 32'h3C);

    txn("t3_absent", 1'b0, 7'h33, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 176, 0, 1'b0, 0);
    chk("t3_ack_err", 32'(ack_err), 1);
    chk("t3_data_rd_held", 32'(data_rd), 32'h3C);

    txn("t4_ignore", 1'b0, 7'h11, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 320, 40, 1'b1, 0);
    chk("t4_busy_after", 32'(busy), 0);

    txn("t5_data_nack", 1'b0, 7'h7F, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 320, 0, 1'b0, 0);
    chk("t5_ack_err", 32'(ack_err), 1);
    txn("t5_read_ff", 1'b1, 7'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 320, 0, 1'b0, 0);
    chk("t5_data_rd", 32'(data_rd), 32'hFF);
    txn("t5_read_81", 1'b1, 7'h55, 8'h00, 1'b1, 1'b1, 8'h81, 1'b0, 320, 0, 1'b0, 0);
    chk("t5_data_rd2", 32'(data_rd), 32'h81);

    // data slot 14 = bit 3 of 0xA5 (a driven 0), just after SCL drops
    txn("t6_abort", 1'b0, 7'h2A, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 320, 0, 1'b0, 225);
    repeat (2) @(negedge clk);
    txn("t6_after", 1'b0, 7'h3C, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0, 320, 0, 1'b0, 0);
    chk("t6_data_byte", 32'(mon_dbyte), 32'hC3);
    chk("t6_ack_err", 32'(ack_err), 0);

    txn("t7_stretch", 1'b0, 7'h2A, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1, STRETCH ? 330 : 320, 0, 1'b0, 0);
    chk("t7_data_byte", 32'(mon_dbyte), 32'hA5);
    chk("t7_ack_err", 32'(ack_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
